// File: rtl/clint_pkg.sv
// Shared constants, register-select encoding and helpers for the core-local interruptor.
package clint_pkg;

  localparam int unsigned clint_clk_divider_rtc = 380;

  localparam logic [15:0] clint_msip_off        = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_off    = 16'h4000;
  localparam logic [15:0] clint_mtime_off       = 16'hBFF8;
  localparam logic [15:0] clint_mtimecmp_hi_off = clint_mtimecmp_off + 16'd4;
  localparam logic [15:0] clint_mtime_hi_off    = clint_mtime_off + 16'd4;

  localparam logic [63:0] clint_mtimecmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } clint_sel_e;

  // Word-granular decode; byte offset bits are not part of the match.
  function automatic clint_sel_e clint_decode(input logic [15:2] word);
    clint_sel_e sel;
    sel = SEL_NONE;
    if (word == clint_msip_off[15:2])             sel = SEL_MSIP;
    else if (word == clint_mtimecmp_off[15:2])    sel = SEL_CMP_LO;
    else if (word == clint_mtimecmp_hi_off[15:2]) sel = SEL_CMP_HI;
    else if (word == clint_mtime_off[15:2])       sel = SEL_TIME_LO;
    else if (word == clint_mtime_hi_off[15:2])    sel = SEL_TIME_HI;
    return sel;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/clint_if.sv
// Request/response bus between the address decoder, the CLINT and the core's interrupt inputs.
interface clint_if;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        clint_msip;
  logic        clint_mtip;

  modport master (
    output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    input  clint_rdata, clint_ready, clint_msip, clint_mtip
  );

  modport slave (
    input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    output clint_rdata, clint_ready, clint_msip, clint_mtip
  );
endinterface

// File: rtl/clint_rtc.sv
// Real-time tick generator: divides the core clock into an rtc level and emits
// a one-cycle pulse on each rising edge of that level.
module clint_rtc
  import clint_pkg::*;
#(
  parameter int unsigned clk_divider_rtc = clint_clk_divider_rtc
) (
  input  logic clock,
  input  logic reset,
  output logic rtc_tick
);

  localparam int unsigned CW = (clk_divider_rtc < 1) ? 1 : $clog2(clk_divider_rtc + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rtc_q, rtc_d, rtc_prev_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(clk_divider_rtc));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    rtc_d = rtc_q ^ wrap;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      rtc_q      <= 1'b0;
      rtc_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rtc_q      <= rtc_d;
      rtc_prev_q <= rtc_q;
    end
  end

  assign rtc_tick = rtc_q & ~rtc_prev_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtime/mtimecmp with byte-masked access,
// registered timer compare and a fixed one-cycle response.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned clk_divider_rtc = clint_clk_divider_rtc
) (
  input  logic    clock,
  input  logic    reset,
  clint_if.slave  bus
);

  logic        rtc_tick;
  clint_sel_e  sel;
  logic        wr_en;
  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] cmp_q, cmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        unused_ok;

  clint_rtc #(.clk_divider_rtc(clk_divider_rtc)) u_rtc (
    .clock    (clock),
    .reset    (reset),
    .rtc_tick (rtc_tick)
  );

  // Fetch flag and out-of-window address bits carry no meaning here.
  assign unused_ok = ^{bus.clint_instr, bus.clint_addr[31:16], bus.clint_addr[1:0]};

  assign sel   = clint_decode(bus.clint_addr[15:2]);
  assign wr_en = bus.clint_valid & (|bus.clint_wstrb);

  // Read mux sees pre-write, pre-increment state.
  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_MSIP:    rd_mux = {31'b0, msip_q};
      SEL_CMP_LO:  rd_mux = cmp_q[31:0];
      SEL_CMP_HI:  rd_mux = cmp_q[63:32];
      SEL_TIME_LO: rd_mux = mtime_q[31:0];
      SEL_TIME_HI: rd_mux = mtime_q[63:32];
      default:     rd_mux = '0;
    endcase
  end

  // Written bytes override the incremented mtime; untouched bytes keep the tick.
  always_comb begin
    mtime_inc = mtime_q + 64'(rtc_tick);
    mtime_d   = mtime_inc;
    cmp_d     = cmp_q;
    msip_d    = msip_q;
    rdata_d   = bus.clint_valid ? rd_mux : '0;
    if (wr_en) begin
      case (sel)
        SEL_MSIP:    if (bus.clint_wstrb[0]) msip_d = bus.clint_wdata[0];
        SEL_CMP_LO:  cmp_d[31:0]    = byte_merge(cmp_q[31:0],      bus.clint_wdata, bus.clint_wstrb);
        SEL_CMP_HI:  cmp_d[63:32]   = byte_merge(cmp_q[63:32],     bus.clint_wdata, bus.clint_wstrb);
        SEL_TIME_LO: mtime_d[31:0]  = byte_merge(mtime_inc[31:0],  bus.clint_wdata, bus.clint_wstrb);
        SEL_TIME_HI: mtime_d[63:32] = byte_merge(mtime_inc[63:32], bus.clint_wdata, bus.clint_wstrb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q <= '0;
      cmp_q   <= clint_mtimecmp_rst;
      msip_q  <= 1'b0;
      mtip_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      mtip_q  <= (mtime_q >= cmp_q);
      ready_q <= bus.clint_valid;
      rdata_q <= rdata_d;
    end
  end

  assign bus.clint_rdata = rdata_q;
  assign bus.clint_ready = ready_q;
  assign bus.clint_msip  = msip_q;
  assign bus.clint_mtip  = mtip_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: vector table, hand-written timing sequences and random
// traffic checked every cycle against a word-level reference model.
module tb_clint;

  localparam int D   = 3;
  localparam int P   = 2 * (D + 1);
  localparam int TPH = (D + 2) % P;

  logic clock = 1'b0;
  logic reset = 1'b1;

  clint_if bus();

  clint #(.clk_divider_rtc(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: register file as plain 64-bit values, ticks by cycle count.
  logic [63:0] m_time, m_cmp;
  logic        m_msip;
  int unsigned edge_cnt;
  logic        e_ready, e_mtip, e_msip;
  logic [31:0] e_rdata;

  function automatic logic [31:0] m_read(input logic [15:0] a);
    case (a)
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_time[31:0];
      16'hBFFC: return m_time[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_time = 64'h0; m_cmp = '1; m_msip = 1'b0; edge_cnt = 0;
    e_ready = 1'b0; e_mtip = 1'b0; e_msip = 1'b0; e_rdata = 32'h0;
  endtask

  always @(posedge clock) begin
    logic [15:0] a;
    logic [63:0] nt;
    if (!reset) begin
      a = bus.clint_addr[15:0];
      a[1:0] = 2'b00;
      edge_cnt = edge_cnt + 1;
      e_ready = bus.clint_valid;
      e_rdata = bus.clint_valid ? m_read(a) : 32'h0;
      e_mtip  = (m_time >= m_cmp);
      nt = m_time + ((edge_cnt % P == TPH) ? 64'd1 : 64'd0);
      if (bus.clint_valid && bus.clint_wstrb != 4'b0) begin
        case (a)
          16'h0000: if (bus.clint_wstrb[0]) m_msip = bus.clint_wdata[0];
          16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0],  bus.clint_wdata, bus.clint_wstrb);
          16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], bus.clint_wdata, bus.clint_wstrb);
          16'hBFF8: nt[31:0]     = merge(nt[31:0],     bus.clint_wdata, bus.clint_wstrb);
          16'hBFFC: nt[63:32]    = merge(nt[63:32],    bus.clint_wdata, bus.clint_wstrb);
          default: ;
        endcase
      end
      m_time = nt;
      e_msip = m_msip;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && chk_en) begin
      check("ready", 64'(bus.clint_ready), 64'(e_ready));
      check("mtip",  64'(bus.clint_mtip),  64'(e_mtip));
      check("msip",  64'(bus.clint_msip),  64'(e_msip));
      if (e_ready) check("rdata", 64'(bus.clint_rdata), 64'(e_rdata));
    end
  end

  // Called at a negedge; leaves valid asserted so consecutive calls are back-to-back.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd);
    bus.clint_valid = 1'b1;
    bus.clint_instr = 1'($urandom);
    bus.clint_addr  = a;
    bus.clint_wdata = wd;
    bus.clint_wstrb = st;
    @(posedge clock);
    @(negedge clock);
    rd = bus.clint_rdata;
  endtask

  task automatic idle(input int n);
    bus.clint_valid = 1'b0;
    bus.clint_wstrb = 4'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd;
    int t20, tm;
    bus.clint_valid = 1'b0; bus.clint_instr = 1'b0; bus.clint_addr = '0;
    bus.clint_wdata = '0;   bus.clint_wstrb = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    release_reset();

    // Tick rate: 80 cycles at period 8
    repeat (80) @(negedge clock);
    access(32'h0200_BFF8, 32'h0, 4'h0, rd);
    checks++;
    if (rd < 32'd9 || rd > 32'd11) begin
      errors++;
      $display("FAIL tick_rate: got %0d expected 10+-1", rd);
    end
    access(32'h0200_0000, 32'h1, 4'h1, rd);
    access(32'h0200_4000, 32'h5, 4'hF, rd);
    idle(1);

    // Reset while a response is pending
    bus.clint_valid = 1'b1; bus.clint_addr = 32'h0200_BFF8; bus.clint_wstrb = 4'h0;
    @(posedge clock);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_ready", 64'(bus.clint_ready), 64'd0);
    check("rst_rdata", 64'(bus.clint_rdata), 64'd0);
    check("rst_mtip",  64'(bus.clint_mtip),  64'd0);
    check("rst_msip",  64'(bus.clint_msip),  64'd0);
    bus.clint_valid = 1'b0;
    repeat (2) @(negedge clock);
    release_reset();
    @(negedge clock);

    tbl.push_back('{32'h0200_BFF8, 32'h0,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_BFFC, 32'h0,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_0000, 32'h0,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_4000, 32'h0,        4'h0, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{32'h0200_4004, 32'h0,        4'h0, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{32'h0200_0000, 32'h1,        4'h1, 1'b0, 32'h0});
    tbl.push_back('{32'h0200_0000, 32'h0,        4'h0, 1'b1, 32'h1});
    tbl.push_back('{32'h0200_0000, 32'h0,        4'h2, 1'b0, 32'h0});
    tbl.push_back('{32'h0200_0000, 32'h0,        4'h0, 1'b1, 32'h1});
    tbl.push_back('{32'h0200_0002, 32'h0,        4'h0, 1'b1, 32'h1});
    tbl.push_back('{32'h0200_4000, 32'h1234_5678, 4'h5, 1'b0, 32'h0});
    tbl.push_back('{32'h0200_4000, 32'h0,        4'h0, 1'b1, 32'hFF34_FF78});
    tbl.push_back('{32'h0200_1000, 32'h0,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_8000, 32'h0,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_4000, 32'h0,        4'h0, 1'b1, 32'hFF34_FF78});
    tbl.push_back('{32'h0200_0000, 32'h0,        4'h1, 1'b0, 32'h0});
    tbl.push_back('{32'h0200_0000, 32'h1,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_0000, 32'h0,        4'h0, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_4000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd);
      if (tbl[i].chk) check($sformatf("vec%0d", i), 64'(rd), 64'(tbl[i].exp));
    end
    idle(1);

    // Timer interrupt: compare at 20, then push it out of reach
    access(32'h0200_4000, 32'd20, 4'hF, rd);
    access(32'h0200_4004, 32'd0,  4'hF, rd);
    idle(0);
    t20 = -1; tm = -1;
    for (int k = 0; k < 400 && tm < 0; k++) begin
      @(negedge clock);
      if (m_time == 64'd20 && t20 < 0) t20 = k;
      if (bus.clint_mtip && tm < 0) tm = k;
    end
    checks++;
    if (tm < 0 || t20 < 0 || tm - t20 != 1) begin
      errors++;
      $display("FAIL mtip_rise: mtip at %0d expected one after mtime==20 at %0d", tm, t20);
    end
    access(32'h0200_4004, 32'd1, 4'hF, rd);
    check("mtip_hold", 64'(bus.clint_mtip), 64'd1);
    idle(1);
    check("mtip_fall", 64'(bus.clint_mtip), 64'd0);

    // 64-bit wrap, then lo->hi carry
    access(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, rd);
    access(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
    idle(8);
    access(32'h0200_BFF8, 32'h0, 4'h0, rd);
    check("wrap_lo", 64'(rd), 64'd0);
    access(32'h0200_BFFC, 32'h0, 4'h0, rd);
    check("wrap_hi", 64'(rd), 64'd0);
    access(32'h0200_BFFC, 32'h0,         4'hF, rd);
    access(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
    idle(8);
    access(32'h0200_BFF8, 32'h0, 4'h0, rd);
    check("carry_lo", 64'(rd), 64'd0);
    access(32'h0200_BFFC, 32'h0, 4'h0, rd);
    check("carry_hi", 64'(rd), 64'd1);
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 6))
        0: a = 32'h0000;
        1: a = 32'h4000;
        2: a = 32'h4004;
        3: a = 32'hBFF8;
        4: a = 32'hBFFC;
        default: a = {16'h0, 16'($urandom)};
      endcase
      a[31:16] = 16'($urandom);
      a[1:0]   = 2'($urandom);
      access(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), rd);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
